// File: rtl/vector_hazard_unit.sv
// Hazard and forwarding controller for the vector pipeline: EX operand forwarding,
// load-use bubbles and a counter-driven freeze while a multi-cycle load occupies MEM.
module vector_hazard_unit #(
  parameter int REG_BITS = 4,
  parameter int LOAD_LAT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [REG_BITS-1:0] id_rs1,
  input  logic [REG_BITS-1:0] id_rs2,
  input  logic [REG_BITS-1:0] ex_rs1,
  input  logic [REG_BITS-1:0] ex_rs2,
  input  logic [REG_BITS-1:0] ex_rd,
  input  logic                ex_memread,
  input  logic [REG_BITS-1:0] mem_rd,
  input  logic                mem_regwrite,
  input  logic                mem_memread,
  input  logic [REG_BITS-1:0] wb_rd,
  input  logic                wb_regwrite,
  input  logic                branch_taken,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic                stall_if,
  output logic                stall_id,
  output logic                stall_ex,
  output logic                stall_mem,
  output logic                flush_id,
  output logic                flush_ex,
  output logic [1:0]          dbg_state
);

  localparam int CW = $clog2(LOAD_LAT + 1);
  localparam bit MULTI = (LOAD_LAT > 1);
  localparam logic [CW-1:0] CNT_INIT = MULTI ? CW'(LOAD_LAT - 2) : '0;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          freeze;
  logic          lu;

  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // The IDLE cycle that sees the load is itself frozen, so cnt holds the number of
  // WAIT cycles still to come; RELEASE is the last cycle the load spends in MEM.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (MULTI && mem_memread) begin
          cnt_nxt   = CNT_INIT;
          state_nxt = (CNT_INIT == '0) ? ST_RELEASE : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt <= CNT_ONE) begin
          cnt_nxt   = '0;
          state_nxt = ST_RELEASE;
        end else begin
          cnt_nxt = cnt - CNT_ONE;
        end
      end
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  assign freeze = ((state == ST_IDLE) && mem_memread && MULTI) || (state == ST_WAIT);
  assign lu     = ex_memread && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  // Stall means "hold the register"; flush means "load a bubble". While rst_n is low
  // every control is forced inactive so the pipeline sees a clean reset.
  always_comb begin
    fwd_a     = 2'b00;
    fwd_b     = 2'b00;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    if (rst_n) begin
      if (mem_regwrite && (mem_rd == ex_rs1))      fwd_a = 2'b10;
      else if (wb_regwrite && (wb_rd == ex_rs1))   fwd_a = 2'b01;
      if (mem_regwrite && (mem_rd == ex_rs2))      fwd_b = 2'b10;
      else if (wb_regwrite && (wb_rd == ex_rs2))   fwd_b = 2'b01;

      if (freeze) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
      end else if (branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (lu) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vector_hazard_unit.sv
// Directed bench for vector_hazard_unit: table of combinational vectors followed by
// hand-written freeze, back-to-back, branch-during-freeze and reset-in-WAIT sequences.
module tb_vector_hazard_unit;

  logic       clk;
  logic       rst_n;
  logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       ex_memread, mem_regwrite, mem_memread, wb_regwrite, branch_taken;
  logic [1:0] fwd_a, fwd_b, dbg_state;
  logic       stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex;

  int checks = 0;
  int errors = 0;

  // Expected word layout: {state[1:0], fwd_a[1:0], fwd_b[1:0], stalls if/id/ex/mem, flush id/ex}
  localparam logic [3:0] S_NO = 4'b0000, S_LU = 4'b1100, S_FZ = 4'b1111;
  localparam logic [1:0] F_NO = 2'b00, F_LU = 2'b01, F_BR = 2'b11;
  localparam logic [1:0] IDL = 2'd0, WT = 2'd1, REL = 2'd2;

  typedef struct {
    string      name;
    logic [3:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd;
    logic       ex_memread;
    logic [3:0] mem_rd;
    logic       mem_regwrite;
    logic [3:0] wb_rd;
    logic       wb_regwrite, branch_taken;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[$];

  vector_hazard_unit #(.REG_BITS(4), .LOAD_LAT(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .ex_memread(ex_memread), .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
    .mem_memread(mem_memread), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .branch_taken(branch_taken), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(string name, logic [3:0] i1, logic [3:0] i2, logic [3:0] e1,
                              logic [3:0] e2, logic [3:0] erd, logic emr, logic [3:0] mrd,
                              logic mrw, logic [3:0] wrd, logic wrw, logic br, logic [11:0] exp);
    vec_t v;
    v.name = name; v.id_rs1 = i1; v.id_rs2 = i2; v.ex_rs1 = e1; v.ex_rs2 = e2; v.ex_rd = erd;
    v.ex_memread = emr; v.mem_rd = mrd; v.mem_regwrite = mrw; v.wb_rd = wrd;
    v.wb_regwrite = wrw; v.branch_taken = br; v.exp = exp;
    return v;
  endfunction

  task automatic clear_inputs();
    id_rs1 = 0; id_rs2 = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_memread = 0; mem_regwrite = 0; mem_memread = 0; wb_regwrite = 0; branch_taken = 0;
  endtask

  task automatic apply(vec_t v);
    id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2;
    ex_rd = v.ex_rd; ex_memread = v.ex_memread; mem_rd = v.mem_rd;
    mem_regwrite = v.mem_regwrite; wb_rd = v.wb_rd; wb_regwrite = v.wb_regwrite;
    branch_taken = v.branch_taken; mem_memread = 1'b0;
  endtask

  // scoreboard compare
  task automatic chk(string name, logic [11:0] exp);
    logic [11:0] obs;
    obs = {dbg_state, fwd_a, fwd_b, stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %b required %b", name, obs, exp);
    end
  endtask

  // check at the falling edge, then advance to just after the next rising edge
  task automatic cyc_chk(string name, logic [11:0] exp);
    @(negedge clk);
    chk(name, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    // reset with every trigger asserted: all outputs must read zero
    rst_n = 1'b0;
    mem_memread = 1; branch_taken = 1; ex_rs1 = 3; mem_rd = 3; mem_regwrite = 1;
    ex_memread = 1; ex_rd = 2; id_rs1 = 2;
    #3;
    chk("reset_outputs", {IDL, 2'b00, 2'b00, S_NO, F_NO});
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    vecs.push_back(mk("fwd_mem_over_wb", 1, 2, 3, 5, 0, 0, 3, 1, 3, 1, 0, {IDL, 2'b10, 2'b00, S_NO, F_NO}));
    vecs.push_back(mk("fwd_wb_only",     1, 2, 3, 5, 0, 0, 3, 0, 3, 1, 0, {IDL, 2'b01, 2'b00, S_NO, F_NO}));
    vecs.push_back(mk("fwd_b_mem_a_wb",  1, 2, 3, 7, 0, 0, 7, 1, 3, 1, 0, {IDL, 2'b01, 2'b10, S_NO, F_NO}));
    vecs.push_back(mk("fwd_reg0",        1, 2, 0, 0, 9, 0, 0, 1, 0, 0, 0, {IDL, 2'b10, 2'b10, S_NO, F_NO}));
    vecs.push_back(mk("fwd_no_regwrite", 1, 2, 4, 4, 9, 0, 4, 0, 4, 0, 0, {IDL, 2'b00, 2'b00, S_NO, F_NO}));
    vecs.push_back(mk("fwd_wb15_mem14",  1, 2, 15, 14, 9, 0, 14, 1, 15, 1, 0, {IDL, 2'b01, 2'b10, S_NO, F_NO}));
    vecs.push_back(mk("lu_rs2",          1, 2, 8, 8, 2, 1, 9, 0, 9, 0, 0, {IDL, 2'b00, 2'b00, S_LU, F_LU}));
    vecs.push_back(mk("lu_rs1",          9, 3, 8, 8, 9, 1, 9, 0, 10, 0, 0, {IDL, 2'b00, 2'b00, S_LU, F_LU}));
    vecs.push_back(mk("load_no_match",   1, 3, 8, 8, 2, 1, 9, 0, 9, 0, 0, {IDL, 2'b00, 2'b00, S_NO, F_NO}));
    vecs.push_back(mk("match_no_load",   2, 2, 8, 8, 2, 0, 9, 0, 9, 0, 0, {IDL, 2'b00, 2'b00, S_NO, F_NO}));
    vecs.push_back(mk("branch_over_lu",  2, 2, 8, 8, 2, 1, 9, 0, 9, 0, 1, {IDL, 2'b00, 2'b00, S_NO, F_BR}));
    vecs.push_back(mk("branch_alone",    1, 2, 8, 8, 3, 0, 9, 0, 9, 0, 1, {IDL, 2'b00, 2'b00, S_NO, F_BR}));

    foreach (vecs[i]) begin
      apply(vecs[i]);
      cyc_chk(vecs[i].name, vecs[i].exp);
    end

    // load-use bubble, then the load reaches MEM and starts the freeze; back-to-back load
    clear_inputs();
    ex_memread = 1; ex_rd = 2; id_rs2 = 2; id_rs1 = 1;
    cyc_chk("seq_lu_bubble", {IDL, 2'b00, 2'b00, S_LU, F_LU});
    clear_inputs();
    mem_memread = 1;
    cyc_chk("seq_frz_c0", {IDL, 2'b00, 2'b00, S_FZ, F_NO});
    cyc_chk("seq_frz_c1", {WT, 2'b00, 2'b00, S_FZ, F_NO});
    cyc_chk("seq_frz_c2", {WT, 2'b00, 2'b00, S_FZ, F_NO});
    cyc_chk("seq_release_no_retrig", {REL, 2'b00, 2'b00, S_NO, F_NO});
    cyc_chk("seq_b2b_c4", {IDL, 2'b00, 2'b00, S_FZ, F_NO});
    cyc_chk("seq_b2b_c5", {WT, 2'b00, 2'b00, S_FZ, F_NO});
    cyc_chk("seq_b2b_c6", {WT, 2'b00, 2'b00, S_FZ, F_NO});
    mem_memread = 0;
    cyc_chk("seq_b2b_release", {REL, 2'b00, 2'b00, S_NO, F_NO});
    cyc_chk("seq_idle_after", {IDL, 2'b00, 2'b00, S_NO, F_NO});

    // branch held during freeze, forwarding still live in WAIT
    mem_memread = 1;
    cyc_chk("br_frz_c0", {IDL, 2'b00, 2'b00, S_FZ, F_NO});
    branch_taken = 1; ex_rs1 = 6; mem_rd = 6; mem_regwrite = 1;
    cyc_chk("br_frz_c1", {WT, 2'b10, 2'b00, S_FZ, F_NO});
    cyc_chk("br_frz_c2", {WT, 2'b10, 2'b00, S_FZ, F_NO});
    cyc_chk("br_release_flush", {REL, 2'b10, 2'b00, S_NO, F_BR});
    clear_inputs();
    cyc_chk("br_after", {IDL, 2'b00, 2'b00, S_NO, F_NO});

    // asynchronous reset in the middle of a WAIT cycle
    mem_memread = 1;
    cyc_chk("rst_frz_c0", {IDL, 2'b00, 2'b00, S_FZ, F_NO});
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wait", {IDL, 2'b00, 2'b00, S_NO, F_NO});
    @(negedge clk);
    mem_memread = 0;
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc_chk("rst_after_release", {IDL, 2'b00, 2'b00, S_NO, F_NO});
    mem_memread = 1;
    cyc_chk("rst_refrz_c0", {IDL, 2'b00, 2'b00, S_FZ, F_NO});
    mem_memread = 0;
    cyc_chk("rst_refrz_c1", {WT, 2'b00, 2'b00, S_FZ, F_NO});
    cyc_chk("rst_refrz_c2", {WT, 2'b00, 2'b00, S_FZ, F_NO});
    cyc_chk("rst_refrz_rel", {REL, 2'b00, 2'b00, S_NO, F_NO});

    // final report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
